// File: rtl/vpu_src_sram_resp_if.sv
// Request/response/preload bundle between the VPU source-port host and its SRAM responder.
// The host side uses the master modport; the responder uses slave.
interface vpu_src_sram_resp_if #(
    parameter int DWIDTH = 256,
    parameter int AWIDTH = 10
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [AWIDTH-1:0] req_addr_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DWIDTH-1:0] rsp_data_o;
    logic              wr_en_i;
    logic [AWIDTH-1:0] wr_addr_i;
    logic [DWIDTH-1:0] wr_data_i;
    logic              err_o;

    modport master (
        output req_valid_i, req_addr_i, rsp_ready_i, wr_en_i, wr_addr_i, wr_data_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, err_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, rsp_ready_i, wr_en_i, wr_addr_i, wr_data_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, err_o
    );
endinterface

// File: rtl/vpu_src_sram_resp.sv
// SRAM-side responder for one VPU source read port. It runs a fixed-latency read pipeline
// into a credit-protected response FIFO and has a side port for preload writes.
module vpu_src_sram_resp #(
    parameter int DWIDTH     = 256,
    parameter int AWIDTH     = 10,
    parameter int DEPTH      = 1024,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input logic              clk,
    input logic              rst_n,
    vpu_src_sram_resp_if.slave bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [AWIDTH:0] DEPTH_LIM   = (AWIDTH + 1)'(DEPTH);
    localparam logic [CW-1:0]   CREDITS_MAX = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0]   PTR_LAST    = PW'(FIFO_DEPTH - 1);

    logic [DWIDTH-1:0] mem      [DEPTH];
    logic [DWIDTH-1:0] fifo_mem [FIFO_DEPTH];

    logic [CW-1:0]     credits;
    logic [CW-1:0]     count;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              accept;
    logic              pop;
    logic              rd_in_range;
    logic              wr_in_range;
    logic [DWIDTH-1:0] rd_word;
    logic              last_valid;
    logic [DWIDTH-1:0] last_data;
    logic              err_q;

    assign rd_in_range = {1'b0, bus.req_addr_i} < DEPTH_LIM;
    assign wr_in_range = {1'b0, bus.wr_addr_i} < DEPTH_LIM;

    // Ready comes from registered credits only, so rsp_ready_i never reaches req_ready_o combinationally.
    assign bus.req_ready_o = (credits != '0);
    assign accept          = bus.req_valid_i && bus.req_ready_o;
    assign bus.rsp_valid_o = (count != '0);
    assign pop             = bus.rsp_valid_o && bus.rsp_ready_i;
    assign bus.rsp_data_o  = bus.rsp_valid_o ? fifo_mem[rd_ptr] : '0;
    assign bus.err_o       = err_q;

    // Out-of-range reads still travel the pipeline, but they carry zero data.
    assign rd_word = rd_in_range ? mem[bus.req_addr_i[IW-1:0]] : '0;

    // NOTE: SRAM and payload storage carry no reset; only the control state is reset.
    always_ff @(posedge clk) begin
        if (bus.wr_en_i && wr_in_range) begin
            mem[bus.wr_addr_i[IW-1:0]] <= bus.wr_data_i;
        end
    end

    generate
        if (RD_LATENCY == 1) begin : g_lat1
            assign last_valid = accept;
            assign last_data  = rd_word;
        end else begin : g_pipe
            logic [RD_LATENCY-2:0] stg_valid;
            logic [DWIDTH-1:0]     stg_data [RD_LATENCY-1];

            // NOTE: sequential state uses non-blocking assignments, so every stage samples its pre-edge value.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stg_valid <= '0;
                end else begin
                    stg_valid[0] <= accept;
                    for (int i = 1; i < RD_LATENCY - 1; i++) begin
                        stg_valid[i] <= stg_valid[i-1];
                    end
                end
            end

            // The SRAM read is registered here. Because the write lands on the same edge, the read sees the old data.
            always_ff @(posedge clk) begin
                stg_data[0] <= rd_word;
                for (int i = 1; i < RD_LATENCY - 1; i++) begin
                    stg_data[i] <= stg_data[i-1];
                end
            end

            assign last_valid = stg_valid[RD_LATENCY-2];
            assign last_data  = stg_data[RD_LATENCY-2];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (last_valid) begin
            fifo_mem[wr_ptr] <= last_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            credits <= CREDITS_MAX;
            err_q   <= 1'b0;
        end else begin
            if (last_valid) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
            end

            case ({last_valid, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            case ({accept, pop})
                2'b10:   credits <= credits - CW'(1);
                2'b01:   credits <= credits + CW'(1);
                default: credits <= credits;
            endcase

            if (accept && !rd_in_range) begin
                err_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vpu_src_sram_resp.sv
// Randomized and directed bench for vpu_src_sram_resp. A transaction-level model tracks
// memory contents, outstanding requests and response arrival times.
module tb_vpu_src_sram_resp;
    localparam int DW    = 256;
    localparam int AW    = 11;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;
    localparam int FD    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vpu_src_sram_resp_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    vpu_src_sram_resp #(
        .DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH), .RD_LATENCY(LAT), .FIFO_DEPTH(FD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            avail;
    } exp_t;

    exp_t          exp_q[$];
    int unsigned   pend[$];
    logic [DW-1:0] ref_mem [DEPTH];
    int            outstanding = 0;
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    bit            exp_err = 1'b0;
    bit            dut_acc;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // One clock cycle. The caller sets inputs just after a negedge; outputs are compared against
    // the model, the model advances, and the task returns at the following negedge.
    task automatic cycle();
        bit   exp_ready, exp_valid, acc, pop, err_next;
        exp_t e;
        int   ra, wa;
        #1;
        exp_ready = (outstanding < FD);
        exp_valid = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
        check("req_ready", DW'(bus.req_ready_o), DW'(exp_ready));
        check("rsp_valid", DW'(bus.rsp_valid_o), DW'(exp_valid));
        check("err", DW'(bus.err_o), DW'(exp_err));
        if (exp_valid) check("rsp_data", bus.rsp_data_o, exp_q[0].data);

        dut_acc  = bus.req_valid_i && bus.req_ready_o;
        acc      = bus.req_valid_i && exp_ready;
        pop      = exp_valid && bus.rsp_ready_i;
        err_next = 1'b0;
        if (pop) void'(exp_q.pop_front());
        if (acc) begin
            ra = int'(bus.req_addr_i);
            if (ra < DEPTH) e.data = ref_mem[ra];
            else begin
                e.data   = '0;
                err_next = 1'b1;
            end
            e.avail = cyc + LAT;
            exp_q.push_back(e);
        end
        wa = int'(bus.wr_addr_i);
        if (bus.wr_en_i && wa < DEPTH) ref_mem[wa] = bus.wr_data_i;
        outstanding += int'(acc) - int'(pop);

        @(posedge clk);
        if (err_next) exp_err = 1'b1;
        cyc++;
        @(negedge clk);
    endtask

    task automatic write_word(input int addr, input logic [DW-1:0] data);
        bus.wr_en_i   = 1'b1;
        bus.wr_addr_i = AW'(addr);
        bus.wr_data_i = data;
        cycle();
        bus.wr_en_i   = 1'b0;
    endtask

    // Send every queued address in order. For the first `stall` cycles rsp_ready_i is held low.
    task automatic send(input int stall, output int n_acc_stall);
        n_acc_stall = 0;
        for (int it = 0; it < 200 && pend.size() > 0; it++) begin
            bus.req_valid_i = 1'b1;
            bus.req_addr_i  = AW'(pend[0]);
            bus.rsp_ready_i = (it >= stall);
            cycle();
            if (it < stall && dut_acc) n_acc_stall++;
            if (dut_acc) void'(pend.pop_front());
        end
        bus.req_valid_i = 1'b0;
        check("send_done", DW'(pend.size()), DW'(0));
    endtask

    task automatic drain();
        bus.rsp_ready_i = 1'b1;
        for (int it = 0; it < 60 && exp_q.size() > 0; it++) cycle();
        check("drain_done", DW'(exp_q.size()), DW'(0));
    endtask

    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_req_ready", DW'(bus.req_ready_o), DW'(1));
        check("rst_rsp_valid", DW'(bus.rsp_valid_o), DW'(0));
        check("rst_rsp_data", bus.rsp_data_o, '0);
        check("rst_err", DW'(bus.err_o), DW'(0));
        exp_q.delete();
        outstanding     = 0;
        exp_err         = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.wr_en_i     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int            n_acc;
        logic [DW-1:0] a5_word;
        logic [DW-1:0] one_word;
        logic [DW-1:0] two_word;

        a5_word  = {(DW / 8){8'hA5}};
        one_word = DW'(1);
        two_word = DW'(2);

        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.rsp_ready_i = 1'b0;
        bus.wr_en_i     = 1'b0;
        bus.wr_addr_i   = '0;
        bus.wr_data_i   = '0;

        // Reset values while rst_n is held low.
        @(negedge clk);
        #1;
        check("init_req_ready", DW'(bus.req_ready_o), DW'(1));
        check("init_rsp_valid", DW'(bus.rsp_valid_o), DW'(0));
        check("init_rsp_data", bus.rsp_data_o, '0);
        check("init_err", DW'(bus.err_o), DW'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Fill the whole SRAM so that every later read has a known value.
        for (int a = 0; a < DEPTH; a++) write_word(a, rand_word());

        // Single read: valid at T+2, then gone at T+3 after the pop.
        write_word(5, a5_word);
        pend.push_back(5);
        send(0, n_acc);
        drain();

        // 16 back-to-back reads with the consumer always ready.
        for (int a = 0; a < 16; a++) pend.push_back(a);
        send(0, n_acc);
        drain();

        // Backpressure: only FIFO_DEPTH requests are accepted while the consumer stalls.
        for (int i = 0; i < 6; i++) pend.push_back($urandom_range(0, DEPTH - 1));
        send(6, n_acc);
        check("bp_accepts", DW'(n_acc), DW'(FD));
        drain();

        // A read and a write to the same address in one cycle: the read returns the old data.
        write_word(7, two_word);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = AW'(7);
        bus.rsp_ready_i = 1'b1;
        write_word(7, one_word);
        bus.req_valid_i = 1'b0;
        pend.push_back(7);
        send(0, n_acc);
        drain();

        // Last legal address and then the first out-of-range one. err_o is sticky.
        write_word(DEPTH - 1, rand_word());
        pend.push_back(DEPTH - 1);
        pend.push_back(DEPTH);
        send(0, n_acc);
        drain();
        for (int i = 0; i < 4; i++) cycle();

        // Reset with three requests outstanding: nothing emerges afterwards.
        bus.rsp_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) pend.push_back(100 + i);
        send(3, n_acc);
        mid_reset();
        bus.rsp_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        pend.push_back(200);
        send(0, n_acc);
        drain();

        // Random traffic: mixed requests, backpressure, preload writes and occasional out-of-range reads.
        for (int i = 0; i < 500; i++) begin
            bus.req_valid_i = ($urandom_range(0, 9) < 6);
            bus.req_addr_i  = AW'($urandom_range(0, DEPTH + 15));
            bus.rsp_ready_i = ($urandom_range(0, 9) < 7);
            bus.wr_en_i     = ($urandom_range(0, 9) < 3);
            bus.wr_addr_i   = AW'($urandom_range(0, DEPTH + 60));
            bus.wr_data_i   = rand_word();
            cycle();
        end
        bus.req_valid_i = 1'b0;
        bus.wr_en_i     = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
